mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the single-cycle MIPS datapath.
- Sits directly downstream of the register file: consumes the two read-port values (rs, rt) and executes MULT, MULTU, DIV and DIVU into internal HI/LO registers.
- HI/LO are read by MFHI/MFLO and written by MTHI/MTLO.
- The controller stalls the pipeline on busy.

Parameters:
- DATA_WIDTH, 32: operand width and HI/LO width.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch operation; sampled only when idle.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- Op_a  input  DATA_WIDTH  rs value (multiplicand/dividend); sampled with start.
- Op_b  input  DATA_WIDTH  rt value (multiplier/divisor); sampled with start.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- WrDta  input  DATA_WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO just updated.
- div_by_zero  output  1  one-cycle pulse with done for DIV/DIVU with Op_b==0.
- Hi  output  DATA_WIDTH  HI register.
- Lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Hi=Lo=0, busy=0, done=0, div_by_zero=0, FSM to IDLE.
  - Reset mid-operation discards the operation with no HI/LO update.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on an edge with start=1, latch op, the operand magnitudes (signed ops use absolute value; unsigned ops use raw values) and the result sign flags. Clear the iteration counter. Go to RUN.
  - RUN: one bit per cycle, DATA_WIDTH cycles.
    - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - After the DATA_WIDTH-th iteration, go to FIX.
  - FIX: apply sign correction, write Hi/Lo, pulse done, return to IDLE.
- Timing, with start sampled at edge 0:
  - busy=1 after edges 0 through DATA_WIDTH (DATA_WIDTH+1 cycles).
  - Edge DATA_WIDTH+1 (edge 33 at default) updates Hi/Lo, drops busy, sets done=1 for exactly one cycle.
  - A new start is accepted in the cycle done is high.
- Results:
  - MULT/MULTU: {Hi,Lo} = full 2*DATA_WIDTH product, two's complement for MULT.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero; signed remainder takes the dividend's sign.
  - DIV most-negative / -1: Lo=0x80000000, Hi=0 (no trap).
  - Divide by zero: full latency still applies; Lo=all ones, Hi=Op_a as sampled, div_by_zero pulses with done.
- Operand changes after the start edge have no effect.
- start while busy is ignored; it is not queued.
- hi_we/lo_we:
  - In IDLE, write WrDta to Hi/Lo on the edge.
  - While busy, the writes are ignored.
  - A write and start on the same IDLE edge are both honoured; the operation result later overwrites.
- Hi/Lo hold their values at all other times. Intermediate values are never visible on Hi/Lo.

Test Plan:
- Reset then MULTU Op_a=0xFFFFFFFF, Op_b=0xFFFFFFFF -> done exactly 33 edges after the start edge; Hi=0xFFFFFFFE, Lo=0x00000001; busy high 33 cycles.
- MULT Op_a=-3 (0xFFFFFFFD), Op_b=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU 100/7 -> Lo=0x0000000E, Hi=0x00000002, div_by_zero=0. Then DIVU 5/0 -> Lo=0xFFFFFFFF, Hi=0x00000005, div_by_zero=1 for one cycle with done.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0x1234 in IDLE -> Hi=0x1234 next edge. MULTU 2*3 started, then pulse hi_we and start mid-operation -> both ignored; final Hi=0, Lo=6; single done pulse.
- Start MULTU 9*9, assert rst_n low at iteration 10 -> Hi=Lo=0, busy=0 immediately. No done after release. A new start then produces Lo=0x51.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One bit per cycle, then a sign-fix cycle that commits Hi/Lo and pulses done.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] Op_a,
    input  logic [DATA_WIDTH-1:0] Op_b,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] WrDta,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc, acc_step, prod_fix;
    logic [W-1:0]    opnd, mag_a, mag_b, q_fix, r_fix, hi_res, lo_res;
    logic [W:0]      add_sum, shifted, diff;
    logic            is_div, neg_res, neg_rem, dz;
    logic            signed_op, last_iter;

    assign signed_op = ~op[0];
    assign mag_a     = (signed_op && Op_a[W-1]) ? (~Op_a + 1'b1) : Op_a;
    assign mag_b     = (signed_op && Op_b[W-1]) ? (~Op_b + 1'b1) : Op_b;
    assign last_iter = (cnt == CW'(W - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiply keeps the multiplier in acc low half and shifts right while adding
    // into the high half; divide keeps the remainder high and the dividend/quotient
    // low and shifts left, restoring when the trial subtraction goes negative.
    always_comb begin
        add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
        shifted  = acc[2*W-1:W-1];
        diff     = shifted - {1'b0, opnd};
        acc_step = {add_sum, acc[W-1:1]};
        if (is_div) begin
            if (diff[W])
                acc_step = {shifted[W-1:0], acc[W-2:0], 1'b0};
            else
                acc_step = {diff[W-1:0], acc[W-2:0], 1'b1};
        end
    end

    // Divide by zero naturally yields remainder = |dividend|, which the remainder
    // sign fix turns back into Op_a; only the quotient needs forcing to all ones.
    always_comb begin
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        r_fix    = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
        q_fix    = neg_res ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        if (dz)
            q_fix = {W{1'b1}};
        hi_res   = is_div ? r_fix : prod_fix[2*W-1:W];
        lo_res   = is_div ? q_fix : prod_fix[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                cnt     <= '0;
                is_div  <= op[1];
                neg_res <= signed_op && (Op_a[W-1] ^ Op_b[W-1]);
                neg_rem <= signed_op && Op_a[W-1];
                dz      <= op[1] && (Op_b == '0);
                opnd    <= op[1] ? mag_b : mag_a;
                acc     <= {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
            end
        end else if (state == RUN) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hi          <= '0;
            Lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && dz;
            if (state == FIX) begin
                Hi <= hi_res;
                Lo <= lo_res;
            end else if (state == IDLE) begin
                if (hi_we) Hi <= WrDta;
                if (lo_we) Lo <= WrDta;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, corner cases, MTHI/MTLO and reset.
module tb_mult_div_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] Op_a;
    logic [31:0] Op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] WrDta;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int pass_cnt  = 0;
    int check_cnt = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .Op_a(Op_a), .Op_b(Op_b), .hi_we(hi_we), .lo_we(lo_we), .WrDta(WrDta),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .Hi(Hi), .Lo(Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge where done is seen (or after the budget).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, output int lat, output int busy_cyc);
        op = o; Op_a = a; Op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; Op_a = 32'hA5A5A5A5; Op_b = 32'h3C3C3C3C; op = ~o;
        lat = 0; busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            if (lat == inject_at) begin
                hi_we = 1'b1; lo_we = 1'b1; WrDta = 32'hDEADBEEF; start = 1'b1;
            end
            @(negedge clk);
            hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; Op_a = '0; Op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; WrDta = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++; if (Hi !== 32'h0) $display("[TB] FAIL reset_hi got %h want %h", Hi, 32'h0); else pass_cnt++;
        check_cnt++; if (Lo !== 32'h0) $display("[TB] FAIL reset_lo got %h want %h", Lo, 32'h0); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_multu_max();
        int lat, bc;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bc);
        check_cnt++; if (lat != 33) $display("[TB] FAIL multu_latency got %0d want 33", lat); else pass_cnt++;
        check_cnt++; if (bc != 33) $display("[TB] FAIL multu_busy_cycles got %0d want 33", bc); else pass_cnt++;
        check_cnt++; if (Hi !== 32'hFFFFFFFE) $display("[TB] FAIL multu_hi got %h want FFFFFFFE", Hi); else pass_cnt++;
        check_cnt++; if (Lo !== 32'h00000001) $display("[TB] FAIL multu_lo got %h want 00000001", Lo); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (done !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL multu_done_pulse got done=%b busy=%b want 0/0", done, busy); else pass_cnt++;
    endtask

    task automatic test_mult_div_signed();
        int lat, bc;
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, -1, lat, bc);
        check_cnt++; if (Hi !== 32'hFFFFFFFF) $display("[TB] FAIL mult_hi got %h want FFFFFFFF", Hi); else pass_cnt++;
        check_cnt++; if (Lo !== 32'hFFFFFFEB) $display("[TB] FAIL mult_lo got %h want FFFFFFEB", Lo); else pass_cnt++;
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, lat, bc);
        check_cnt++; if (Lo !== 32'hFFFFFFFD) $display("[TB] FAIL div_quot got %h want FFFFFFFD", Lo); else pass_cnt++;
        check_cnt++; if (Hi !== 32'hFFFFFFFF) $display("[TB] FAIL div_rem got %h want FFFFFFFF", Hi); else pass_cnt++;
    endtask

    task automatic test_divu_and_zero();
        int lat, bc;
        run_op(2'b11, 32'd100, 32'd7, -1, lat, bc);
        check_cnt++; if (Lo !== 32'h0000000E) $display("[TB] FAIL divu_quot got %h want 0000000E", Lo); else pass_cnt++;
        check_cnt++; if (Hi !== 32'h00000002) $display("[TB] FAIL divu_rem got %h want 00000002", Hi); else pass_cnt++;
        check_cnt++; if (div_by_zero !== 1'b0) $display("[TB] FAIL divu_dz got %b want 0", div_by_zero); else pass_cnt++;
        run_op(2'b11, 32'd5, 32'd0, -1, lat, bc);
        check_cnt++; if (lat != 33) $display("[TB] FAIL dz_latency got %0d want 33", lat); else pass_cnt++;
        check_cnt++; if (Lo !== 32'hFFFFFFFF) $display("[TB] FAIL dz_quot got %h want FFFFFFFF", Lo); else pass_cnt++;
        check_cnt++; if (Hi !== 32'h00000005) $display("[TB] FAIL dz_rem got %h want 00000005", Hi); else pass_cnt++;
        check_cnt++; if (div_by_zero !== 1'b1) $display("[TB] FAIL dz_flag got %b want 1", div_by_zero); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (div_by_zero !== 1'b0) $display("[TB] FAIL dz_flag_pulse got %b want 0", div_by_zero); else pass_cnt++;
    endtask

    task automatic test_div_overflow();
        int lat, bc;
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, lat, bc);
        check_cnt++; if (Lo !== 32'h80000000) $display("[TB] FAIL divovf_quot got %h want 80000000", Lo); else pass_cnt++;
        check_cnt++; if (Hi !== 32'h00000000) $display("[TB] FAIL divovf_rem got %h want 00000000", Hi); else pass_cnt++;
    endtask

    task automatic test_hilo_write();
        int lat, bc, extra;
        @(negedge clk);
        hi_we = 1'b1; WrDta = 32'h00001234;
        @(negedge clk);
        hi_we = 1'b0;
        check_cnt++; if (Hi !== 32'h00001234) $display("[TB] FAIL mthi got %h want 00001234", Hi); else pass_cnt++;
        run_op(2'b01, 32'd2, 32'd3, 10, lat, bc);
        check_cnt++; if (lat != 33) $display("[TB] FAIL busy_ignore_latency got %0d want 33", lat); else pass_cnt++;
        check_cnt++; if (Hi !== 32'h0) $display("[TB] FAIL busy_ignore_hi got %h want 00000000", Hi); else pass_cnt++;
        check_cnt++; if (Lo !== 32'h6) $display("[TB] FAIL busy_ignore_lo got %h want 00000006", Lo); else pass_cnt++;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check_cnt++; if (extra != 0) $display("[TB] FAIL start_not_queued got %0d active cycles want 0", extra); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, seen;
        op = 2'b01; Op_a = 32'd9; Op_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cnt++; if (Hi !== 32'h0 || Lo !== 32'h0)
            $display("[TB] FAIL midreset_hilo got %h/%h want 0/0", Hi, Lo); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy got %b want 0", busy); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_cnt++; if (seen != 0) $display("[TB] FAIL midreset_no_done got %0d want 0", seen); else pass_cnt++;
        run_op(2'b01, 32'd9, 32'd9, -1, lat, bc);
        check_cnt++; if (Lo !== 32'h51) $display("[TB] FAIL after_reset_lo got %h want 00000051", Lo); else pass_cnt++;
        check_cnt++; if (Hi !== 32'h0) $display("[TB] FAIL after_reset_hi got %h want 00000000", Hi); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_div_signed();
        test_divu_and_zero();
        test_div_overflow();
        test_hilo_write();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
